// File: rtl/frogger_game_ctrl.sv
// Frogger game controller: multi-lane collision detect, lives/level/score
// bookkeeping, timed HIT/WIN pauses and the level-dependent car speed divider.
module frogger_game_ctrl #(
    parameter int c_LANE_COUNT     = 4,
    parameter int c_LANE_Y0        = 50,
    parameter int c_LANE_PITCH     = 40,
    parameter int c_CAR_W          = 64,
    parameter int c_CAR_H          = 32,
    parameter int c_PLAYER_W       = 32,
    parameter int c_PLAYER_H       = 32,
    parameter int c_GOAL_ROW       = 0,
    parameter int c_LIVES          = 3,
    parameter int c_MAX_LEVEL      = 7,
    parameter int c_RESPAWN_FRAMES = 60,
    parameter int c_WIN_FRAMES     = 30,
    parameter int c_BASE_SPEED     = 100000,
    parameter int c_SPEED_STEP     = 10000,
    parameter int c_MIN_SPEED      = 20000
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset,
    input  logic                       i_Frame_Tick,
    input  logic                       i_Game_Start,
    input  logic [9:0]                 i_Player_X,
    input  logic [9:0]                 i_Player_Y,
    input  logic [10*c_LANE_COUNT-1:0] i_Car_X,
    output logic [2:0]                 o_State,
    output logic                       o_Game_Active,
    output logic                       o_Respawn,
    output logic [7:0]                 o_Score,
    output logic [2:0]                 o_Lives,
    output logic [2:0]                 o_Level,
    output logic [23:0]                o_Car_Speed,
    output logic                       o_Collision
);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        RUNNING   = 3'b001,
        HIT       = 3'b010,
        WIN       = 3'b110,
        GAME_OVER = 3'b100
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              frame_cnt;
    logic                    start_q;
    logic                    start_evt;
    logic                    start_load;
    logic                    player_win;
    logic                    respawn_d;
    logic [c_LANE_COUNT-1:0] lane_hit;
    logic [23:0]             speed_calc;
    logic [10:0]             px;
    logic [10:0]             py;

    assign px = {1'b0, i_Player_X};
    assign py = {1'b0, i_Player_Y};

    // Rectangle overlap per lane, evaluated at 11 bits so edge sums cannot wrap.
    for (genvar k = 0; k < c_LANE_COUNT; k++) begin : g_lane
        localparam logic [10:0] c_Y = 11'(c_LANE_Y0 + k * c_LANE_PITCH);
        logic [10:0] car_x;
        assign car_x       = {1'b0, i_Car_X[10*k +: 10]};
        assign lane_hit[k] = (px < car_x + 11'(c_CAR_W)) &&
                             (px + 11'(c_PLAYER_W) > car_x) &&
                             (py < c_Y + 11'(c_CAR_H)) &&
                             (py + 11'(c_PLAYER_H) > c_Y);
    end

    assign player_win = (i_Player_Y <= 10'(c_GOAL_ROW));
    assign start_evt  = i_Game_Start & ~start_q;
    assign start_load = start_evt && (state == IDLE || state == GAME_OVER);
    assign o_State    = state;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start_evt) state_next = RUNNING;
            RUNNING: begin
                if (player_win)       state_next = WIN;
                else if (o_Collision) state_next = HIT;
            end
            HIT: begin
                if (o_Lives == 3'd0)                            state_next = GAME_OVER;
                else if (frame_cnt == 8'(c_RESPAWN_FRAMES))     state_next = RUNNING;
            end
            WIN:       if (frame_cnt == 8'(c_WIN_FRAMES)) state_next = RUNNING;
            GAME_OVER: if (start_evt) state_next = RUNNING;
            default:   state_next = IDLE;
        endcase
    end

    // Every way into RUNNING from another state puts the player back at the start.
    always_comb begin
        o_Game_Active = (state == RUNNING);
        respawn_d     = (state_next == RUNNING) && (state != RUNNING);
    end

    always_comb begin
        int spd;
        spd = c_BASE_SPEED - int'(o_Level) * c_SPEED_STEP;
        if (spd < c_MIN_SPEED) spd = c_MIN_SPEED;
        speed_calc = spd[23:0];
    end

    // start_q resets high so a button already held at reset release is not an edge.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            start_q     <= 1'b1;
            frame_cnt   <= 8'd0;
            o_Score     <= 8'd0;
            o_Lives     <= 3'(c_LIVES);
            o_Level     <= 3'd0;
            o_Respawn   <= 1'b0;
            o_Collision <= 1'b0;
            o_Car_Speed <= 24'(c_BASE_SPEED);
        end else begin
            start_q     <= i_Game_Start;
            o_Collision <= |lane_hit;
            o_Respawn   <= respawn_d;
            o_Car_Speed <= speed_calc;

            if (state_next != state)
                frame_cnt <= 8'd0;
            else if ((state == HIT || state == WIN) && i_Frame_Tick && frame_cnt != 8'hFF)
                frame_cnt <= frame_cnt + 8'd1;

            if (start_load) begin
                o_Lives <= 3'(c_LIVES);
                o_Score <= 8'd0;
                o_Level <= 3'd0;
            end else if (state == RUNNING) begin
                if (player_win) begin
                    if (o_Score != 8'hFF)             o_Score <= o_Score + 8'd1;
                    if (o_Level != 3'(c_MAX_LEVEL))   o_Level <= o_Level + 3'd1;
                end else if (o_Collision && o_Lives != 3'd0) begin
                    o_Lives <= o_Lives - 3'd1;
                end
            end
        end
    end

endmodule
